// File: rtl/data_mem_responder.sv
// data_mem_responder: data RAM plus memory-mapped output FIFO, status and cycle counter for the core's MEM stage
module data_mem_responder #(
  parameter int WIDTH = 32,
  parameter int RAM_AW = 7,
  parameter int FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] IO_BASE = 'h80
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mem_ctrl_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             bus_err_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
  localparam logic [WIDTH-1:0] A_STA = IO_BASE + WIDTH'(1);
  localparam logic [WIDTH-1:0] A_CYC = IO_BASE + WIDTH'(2);
  logic [WIDTH-1:0] ram_q [2**RAM_AW];
  logic [WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, err_q, err_d;
  logic [WIDTH-1:0] cyc_q, cyc_d, status;
  logic rd, wr, is_ram, is_out, is_sta, is_cyc, legal, full, pop, push_req, push;
  assign rd = mem_ctrl_i == 2'b01;
  assign wr = mem_ctrl_i[1];
  assign is_ram = addr_i < WIDTH'(2**RAM_AW);
  assign is_out = addr_i == IO_BASE;
  assign is_sta = addr_i == A_STA;
  assign is_cyc = addr_i == A_CYC;
  assign legal = is_ram | is_out | is_sta | is_cyc;
  assign full = cnt_q == DEPTH;
  assign out_valid_o = cnt_q != '0;
  assign out_data_o = out_valid_o ? fifo_q[rp_q] : '0;
  assign bus_err_o = err_q;
  assign pop = out_valid_o && out_ready_i;
  assign push_req = wr && is_out;
  assign push = push_req && (!full || pop);
  assign status = WIDTH'({ovf_q, full, cnt_q});
  // Load data mux and next-state for FIFO bookkeeping, overflow, error flag and cycle counter
  always_comb begin
    rdata_o = !rd ? '0 : is_ram ? ram_q[addr_i[RAM_AW-1:0]] : is_sta ? status : is_cyc ? cyc_q : '0;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(pop);
    ovf_d = (push_req && full && !pop) || (ovf_q && !(wr && is_sta && wdata_i[4]));
    err_d = err_q || (mem_ctrl_i != 2'b00 && (!legal || mem_ctrl_i == 2'b11));
    cyc_d = (wr && is_cyc) ? wdata_i : cyc_q + WIDTH'(1);
  end
  // Control state registers; reset discards any same-cycle access
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rp_q <= '0;
      wp_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rp_q <= rp_d;
      wp_q <= wp_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      cyc_q <= cyc_d;
    end
  end
  // RAM and FIFO storage, not cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr && is_ram) ram_q[addr_i[RAM_AW-1:0]] <= wdata_i;
    if (!rst_i && push) fifo_q[wp_q] <= wdata_i;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven vectors with a FIFO scoreboard for data_mem_responder
module tb_data_mem_responder;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [1:0] mem_ctrl = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, out_data;
  logic out_valid, bus_err;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  logic err_m = 1'b0;
  typedef struct {
    logic [1:0] c;
    logic [31:0] a;
    logic [31:0] w;
    logic r;
    logic chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];
  data_mem_responder dut (
    .clk_i(clk), .rst_i(rst), .mem_ctrl_i(mem_ctrl), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .bus_err_o(bus_err)
  );
  always #5 clk = ~clk;
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic vec_t mk_w(logic [31:0] a, logic [31:0] w, logic r);
    vec_t v = '{2'b10, a, w, r, 1'b0, 32'h0};
    return v;
  endfunction
  function automatic vec_t mk_r(logic [31:0] a, logic [31:0] exp, logic r);
    vec_t v = '{2'b01, a, 32'h0, r, 1'b1, exp};
    return v;
  endfunction
  function automatic vec_t mk_i(logic r);
    vec_t v = '{2'b00, 32'h0, 32'h0, r, 1'b0, 32'h0};
    return v;
  endfunction
  task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w, input logic r,
                      input logic rs, input logic chk, input logic [31:0] exp);
    int n;
    logic pop;
    mem_ctrl = c; addr = a; wdata = w; out_ready = r; rst = rs;
    @(negedge clk);
    n = q.size();
    if (chk) check("rdata", rdata, exp);
    check("out_valid", 32'(out_valid), 32'(n > 0));
    check("out_data", out_data, n > 0 ? q[0] : 32'h0);
    check("bus_err", 32'(bus_err), 32'(err_m));
    pop = n > 0 && r && !rs;
    if (pop) void'(q.pop_front());
    if (rs) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      if (c[1] && a == 32'h80 && (n < 4 || pop)) q.push_back(w);
      if (c != 2'b00 && (a > 32'h82 || c == 2'b11)) err_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl.push_back(mk_w(32'h05, 32'hDEADBEEF, 0));
    tbl.push_back(mk_r(32'h05, 32'hDEADBEEF, 0));
    tbl.push_back(mk_w(32'h06, 32'h12345678, 0));
    tbl.push_back(mk_r(32'h06, 32'h12345678, 0));
    tbl.push_back(mk_r(32'h05, 32'hDEADBEEF, 0));
    for (int i = 1; i <= 4; i++) tbl.push_back(mk_w(32'h80, 32'(i), 0));
    tbl.push_back(mk_r(32'h81, 32'h0C, 0));
    tbl.push_back(mk_w(32'h80, 32'h5, 0));
    tbl.push_back(mk_r(32'h81, 32'h1C, 0));
    tbl.push_back(mk_r(32'h80, 32'h0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk_i(1));
    tbl.push_back(mk_r(32'h81, 32'h10, 1));
    tbl.push_back(mk_w(32'h81, 32'h0F, 0));
    tbl.push_back(mk_r(32'h81, 32'h10, 0));
    tbl.push_back(mk_w(32'h81, 32'h10, 0));
    tbl.push_back(mk_r(32'h81, 32'h00, 0));
    for (int i = 1; i <= 4; i++) tbl.push_back(mk_w(32'h80, 32'(i), 0));
    tbl.push_back(mk_w(32'h80, 32'h9, 1));
    tbl.push_back(mk_r(32'h81, 32'h0C, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk_i(1));
    tbl.push_back(mk_r(32'h81, 32'h00, 0));
    tbl.push_back(mk_w(32'h82, 32'hFFFFFFFE, 0));
    tbl.push_back(mk_r(32'h82, 32'hFFFFFFFE, 0));
    tbl.push_back(mk_r(32'h82, 32'hFFFFFFFF, 0));
    tbl.push_back(mk_r(32'h82, 32'h00000000, 0));
    tbl.push_back(mk_w(32'h80, 32'h7, 1));
    tbl.push_back(mk_i(1));
    tbl.push_back(mk_r(32'h90, 32'h0, 0));
    tbl.push_back(mk_r(32'h05, 32'hDEADBEEF, 0));
    tbl.push_back('{2'b11, 32'h05, 32'hAA, 1'b0, 1'b0, 32'h0});
    tbl.push_back(mk_r(32'h05, 32'hAA, 0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b01, 32'h81, 0, 0, 0, 1, 32'h0);
    step(2'b00, 32'h0, 0, 0, 0, 0, 32'h0);
    step(2'b00, 32'h0, 0, 0, 0, 0, 32'h0);
    step(2'b01, 32'h82, 0, 0, 0, 1, 32'h3);
    foreach (tbl[i]) step(tbl[i].c, tbl[i].a, tbl[i].w, tbl[i].r, 1'b0, tbl[i].chk, tbl[i].exp);
    step(2'b10, 32'h80, 32'h11, 0, 0, 0, 32'h0);
    step(2'b10, 32'h80, 32'h22, 0, 0, 0, 32'h0);
    step(2'b10, 32'h82, 32'd50, 0, 0, 0, 32'h0);
    step(2'b01, 32'h82, 0, 0, 0, 1, 32'd50);
    step(2'b10, 32'h80, 32'h33, 0, 1, 0, 32'h0);
    step(2'b01, 32'h82, 0, 0, 0, 1, 32'h0);
    step(2'b01, 32'h81, 0, 0, 0, 1, 32'h0);
    step(2'b01, 32'h05, 0, 0, 0, 1, 32'hAA);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
